// File: rtl/ib_pkg.sv
// Shared definitions for the input-buffer OPU fetch controller: register map of
// the buffer's OPU read port, controller FSM states and default geometry.
package ib_pkg;

  // OPU read-port register map of apb_input_buffer_top
  localparam logic [5:0] OPU_INPUT_INDEX   = 6'h30;
  localparam logic [5:0] OPU_INPUT_PAYLOAD = 6'h34;
  localparam logic [5:0] OPU_INPUT_RELEASE = 6'h38;
  localparam logic [5:0] OPU_INPUT_STATUS  = 6'h3c;

  // Default vector geometry
  localparam int unsigned WORDS_PER_VEC_DEF = 36;
  localparam int unsigned VEC_PER_COL_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_POLL_WAIT,
    ST_SET_IDX,
    ST_RD_PAYLOAD,
    ST_RELEASE,
    ST_OUT,
    ST_DONE
  } fetch_state_e;

  // States that own exactly one APB transfer
  function automatic logic is_xfer_state(fetch_state_e s);
    return (s == ST_POLL) || (s == ST_SET_IDX) || (s == ST_RD_PAYLOAD) ||
           (s == ST_RELEASE);
  endfunction

endpackage

// File: rtl/apb_master_port.sv
// Single-transfer APB master engine.
// Ports:
//   req_i/addr_i/write_i/wdata_i : transfer request, accepted when the port is idle
//                                  or in the same cycle the current transfer completes
//                                  (gives back-to-back SETUP)
//   done_c_o                     : combinational, high on the pready cycle of ACCESS
//   rdata_c_o                    : combinational prdata, valid while done_c_o=1
//   apb_*_m                      : APB master pins (outputs registered)
module apb_master_port #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          req_i,
  input  logic [AW-1:0] addr_i,
  input  logic          write_i,
  input  logic [DW-1:0] wdata_i,
  output logic          done_c_o,
  output logic [DW-1:0] rdata_c_o,
  output logic [AW-1:0] apb_paddr_m,
  output logic          apb_pwrite_m,
  output logic          apb_psel_m,
  output logic          apb_penable_m,
  output logic [DW-1:0] apb_pwdata_m,
  input  logic [DW-1:0] apb_prdata_m,
  input  logic          apb_pready_m
);

  typedef enum logic [1:0] {P_IDLE, P_SETUP, P_ACCESS} port_state_e;

  port_state_e   st_q, st_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          accept_c;

  assign done_c_o  = (st_q == P_ACCESS) && apb_pready_m;
  assign rdata_c_o = apb_prdata_m;
  assign accept_c  = req_i && ((st_q == P_IDLE) || done_c_o);

  // SETUP -> ACCESS -> (idle | next SETUP)
  always_comb begin
    st_d      = st_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    case (st_q)
      P_SETUP: begin
        st_d      = P_ACCESS;
        penable_d = 1'b1;
      end
      P_ACCESS: begin
        if (apb_pready_m) begin
          st_d      = P_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
        end
      end
      default: ;
    endcase
    if (accept_c) begin
      st_d      = P_SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = write_i;
      paddr_d   = addr_i;
      pwdata_d  = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_q      <= P_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      st_q      <= st_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign apb_paddr_m   = paddr_q;
  assign apb_pwrite_m  = pwrite_q;
  assign apb_psel_m    = psel_q;
  assign apb_penable_m = penable_q;
  assign apb_pwdata_m  = pwdata_q;

endmodule

// File: rtl/ib_opu_fetch_ctrl.sv
// OPU fetch controller: polls the input buffer status once per column, then
// gathers VEC_PER_COL vectors word by word over APB (index write + payload read),
// releases each vector and hands it to the OPU on a valid/ready port.
// Ports:
//   start_i/col_cnt_i : launch a run of col_cnt_i columns (ignored while busy)
//   busy_o/done_o     : run in progress / one-cycle completion pulse
//   apb_*_m           : APB master towards apb_input_buffer_top
//   vec_*             : wide vector output; vec_last_o marks a column's last vector
module ib_opu_fetch_ctrl
  import ib_pkg::*;
#(
  parameter int unsigned BUS_AW        = 6,
  parameter int unsigned BUS_DW        = 32,
  parameter int unsigned WORDS_PER_VEC = WORDS_PER_VEC_DEF,
  parameter int unsigned VEC_PER_COL   = VEC_PER_COL_DEF,
  parameter int unsigned POLL_GAP      = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            start_i,
  input  logic [7:0]                      col_cnt_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [BUS_AW-1:0]               apb_paddr_m,
  output logic                            apb_pwrite_m,
  output logic                            apb_psel_m,
  output logic                            apb_penable_m,
  output logic [BUS_DW-1:0]               apb_pwdata_m,
  input  logic [BUS_DW-1:0]               apb_prdata_m,
  input  logic                            apb_pready_m,
  output logic [WORDS_PER_VEC*BUS_DW-1:0] vec_data_o,
  output logic                            vec_valid_o,
  input  logic                            vec_ready_i,
  output logic                            vec_last_o
);

  localparam int unsigned WIDX_W = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1;
  localparam int unsigned VIDX_W = (VEC_PER_COL > 1) ? $clog2(VEC_PER_COL) : 1;
  localparam int unsigned GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int unsigned VEC_W  = WORDS_PER_VEC * BUS_DW;

  fetch_state_e      state_q, state_d;
  logic [WIDX_W-1:0] word_idx_q, word_idx_d;
  logic [VIDX_W-1:0] vec_idx_q, vec_idx_d;
  logic [7:0]        col_rem_q, col_rem_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              busy_q, done_q, valid_q, last_q;
  logic [VEC_W-1:0]  data_q;

  logic              req_c;
  logic [BUS_AW-1:0] addr_c;
  logic              write_c;
  logic [BUS_DW-1:0] wdata_c;
  logic              apb_done_c;
  logic [BUS_DW-1:0] apb_rdata_c;

  apb_master_port #(
    .AW (BUS_AW),
    .DW (BUS_DW)
  ) u_apb (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .req_i         (req_c),
    .addr_i        (addr_c),
    .write_i       (write_c),
    .wdata_i       (wdata_c),
    .done_c_o      (apb_done_c),
    .rdata_c_o     (apb_rdata_c),
    .apb_paddr_m   (apb_paddr_m),
    .apb_pwrite_m  (apb_pwrite_m),
    .apb_psel_m    (apb_psel_m),
    .apb_penable_m (apb_penable_m),
    .apb_pwdata_m  (apb_pwdata_m),
    .apb_prdata_m  (apb_prdata_m),
    .apb_pready_m  (apb_pready_m)
  );

  // Next-state and counter updates
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    vec_idx_d  = vec_idx_q;
    col_rem_d  = col_rem_q;
    gap_d      = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          col_rem_d = col_cnt_i;
          vec_idx_d = '0;
          state_d   = (col_cnt_i == 8'd0) ? ST_DONE : ST_POLL;
        end
      end
      ST_POLL: begin
        if (apb_done_c) begin
          if (apb_rdata_c[0]) begin
            word_idx_d = '0;
            state_d    = ST_SET_IDX;
          end else if (POLL_GAP == 0) begin
            state_d = ST_POLL;
          end else begin
            gap_d   = '0;
            state_d = ST_POLL_WAIT;
          end
        end
      end
      ST_POLL_WAIT: begin
        if (gap_q == GAP_W'(POLL_GAP - 1)) begin
          state_d = ST_POLL;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_SET_IDX: begin
        if (apb_done_c) begin
          state_d = ST_RD_PAYLOAD;
        end
      end
      ST_RD_PAYLOAD: begin
        if (apb_done_c) begin
          if (word_idx_q == WIDX_W'(WORDS_PER_VEC - 1)) begin
            state_d = ST_RELEASE;
          end else begin
            word_idx_d = word_idx_q + WIDX_W'(1);
            state_d    = ST_SET_IDX;
          end
        end
      end
      ST_RELEASE: begin
        if (apb_done_c) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (vec_ready_i) begin
          word_idx_d = '0;
          if (vec_idx_q != VIDX_W'(VEC_PER_COL - 1)) begin
            vec_idx_d = vec_idx_q + VIDX_W'(1);
            state_d   = ST_SET_IDX;
          end else begin
            vec_idx_d = '0;
            col_rem_d = col_rem_q - 8'd1;
            state_d   = (col_rem_q == 8'd1) ? ST_DONE : ST_POLL;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Issue a transfer on entry to a transfer state; entering straight from a
  // completing transfer chains it back-to-back.
  always_comb begin
    req_c   = is_xfer_state(state_d) && (apb_done_c || !is_xfer_state(state_q));
    addr_c  = '0;
    write_c = 1'b0;
    wdata_c = '0;
    case (state_d)
      ST_POLL: begin
        addr_c = BUS_AW'(OPU_INPUT_STATUS);
      end
      ST_SET_IDX: begin
        addr_c  = BUS_AW'(OPU_INPUT_INDEX);
        write_c = 1'b1;
        wdata_c = BUS_DW'(word_idx_d);
      end
      ST_RD_PAYLOAD: begin
        addr_c = BUS_AW'(OPU_INPUT_PAYLOAD);
      end
      ST_RELEASE: begin
        addr_c  = BUS_AW'(OPU_INPUT_RELEASE);
        write_c = 1'b1;
        wdata_c = BUS_DW'(1);
      end
      default: ;
    endcase
  end

  // State, counters, registered outputs and word buffer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      vec_idx_q  <= '0;
      col_rem_q  <= '0;
      gap_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      vec_idx_q  <= vec_idx_d;
      col_rem_q  <= col_rem_d;
      gap_q      <= gap_d;
      busy_q     <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_q     <= (state_d == ST_DONE);
      valid_q    <= (state_d == ST_OUT);
      last_q     <= (state_d == ST_OUT) && (vec_idx_d == VIDX_W'(VEC_PER_COL - 1));
      if ((state_q == ST_RD_PAYLOAD) && apb_done_c) begin
        for (int unsigned w = 0; w < WORDS_PER_VEC; w++) begin
          if (word_idx_q == WIDX_W'(w)) begin
            data_q[w*BUS_DW +: BUS_DW] <= apb_rdata_c;
          end
        end
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign vec_valid_o = valid_q;
  assign vec_last_o  = last_q;
  assign vec_data_o  = data_q;

endmodule

// File: tb/tb_ib_opu_fetch_ctrl.sv
// Directed testbench for ib_opu_fetch_ctrl with a behavioural APB slave
// (payload = index*3, scripted status, optional random wait states).
module tb_ib_opu_fetch_ctrl;

  localparam int unsigned WPV = 36;
  localparam int unsigned VPC = 8;
  localparam int unsigned GAP = 4;
  localparam int unsigned VW  = WPV * 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [7:0]    col_cnt;
  logic          busy, done;
  logic [5:0]    paddr;
  logic          pwrite, psel, penable;
  logic [31:0]   pwdata, prdata;
  logic          pready;
  logic [VW-1:0] vec_data;
  logic          vec_valid, vec_ready, vec_last;

  int errors = 0;
  int checks = 0;

  ib_opu_fetch_ctrl #(
    .BUS_AW(6), .BUS_DW(32), .WORDS_PER_VEC(WPV), .VEC_PER_COL(VPC), .POLL_GAP(GAP)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .col_cnt_i(col_cnt),
    .busy_o(busy), .done_o(done),
    .apb_paddr_m(paddr), .apb_pwrite_m(pwrite), .apb_psel_m(psel),
    .apb_penable_m(penable), .apb_pwdata_m(pwdata), .apb_prdata_m(prdata),
    .apb_pready_m(pready),
    .vec_data_o(vec_data), .vec_valid_o(vec_valid), .vec_ready_i(vec_ready),
    .vec_last_o(vec_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model and monitors ----------------
  logic          clr;
  logic          wait_mode;
  int            zero_target;
  int            cyc;
  logic [1:0]    wait_left;
  logic [5:0]    idx_reg;
  int            poll_n, idx_n, pay_n, rel_n, rel_bad, dir_bad, xfer_n, psel_cyc, done_n;
  int            poll_t [0:7];
  logic          idx_seen;
  logic [31:0]   first_idx;
  int            vec_n;
  logic [VW-1:0] vec_mem [0:31];
  logic          last_mem [0:31];

  assign pready = (wait_left == 2'd0);
  assign prdata = (paddr == 6'h3c) ? ((poll_n >= zero_target) ? 32'd1 : 32'd0) :
                  (paddr == 6'h34) ? (32'(idx_reg) * 32'd3) : 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (clr) begin
      wait_left <= 2'd0; idx_reg <= 6'd0;
      poll_n <= 0; idx_n <= 0; pay_n <= 0; rel_n <= 0; rel_bad <= 0; dir_bad <= 0;
      xfer_n <= 0; psel_cyc <= 0; done_n <= 0; idx_seen <= 1'b0; first_idx <= 32'hffff_ffff;
      vec_n <= 0;
    end else begin
      if (psel && !penable) wait_left <= wait_mode ? 2'($urandom_range(0, 3)) : 2'd0;
      if (psel && penable && (wait_left != 2'd0)) wait_left <= wait_left - 2'd1;
      if (psel) psel_cyc <= psel_cyc + 1;
      if (done) done_n <= done_n + 1;
      if (psel && penable && pready) begin
        xfer_n <= xfer_n + 1;
        if (pwrite !== ((paddr == 6'h30) || (paddr == 6'h38))) dir_bad <= dir_bad + 1;
        case (paddr)
          6'h3c: begin
            poll_n <= poll_n + 1;
            if (poll_n < 8) poll_t[poll_n] <= cyc;
          end
          6'h30: begin
            idx_n   <= idx_n + 1;
            idx_reg <= pwdata[5:0];
            if (!idx_seen) begin
              idx_seen  <= 1'b1;
              first_idx <= pwdata;
            end
          end
          6'h34: pay_n <= pay_n + 1;
          6'h38: begin
            rel_n <= rel_n + 1;
            if (pwdata !== 32'd1) rel_bad <= rel_bad + 1;
          end
          default: ;
        endcase
      end
      if (vec_valid && vec_ready && (vec_n < 32)) begin
        vec_mem[vec_n]  <= vec_data;
        last_mem[vec_n] <= vec_last;
        vec_n           <= vec_n + 1;
      end
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    logic [VW-1:0] v;
    for (int w = 0; w < int'(WPV); w++) v[w*32 +: 32] = 32'(3 * w);
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] n);
    start   = 1'b1;
    col_cnt = n;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done_o not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic check_vectors(input int n, input string name);
    int bad = 0;
    for (int v = 0; v < n; v++) begin
      if (vec_mem[v] !== exp_vec()) bad++;
      if (last_mem[v] !== ((v % int'(VPC)) == int'(VPC) - 1)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_vectors: %0d bad data/last entries of %0d vectors, required 0", name, bad, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({busy, done, psel, penable, pwrite, vec_valid, vec_last} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {busy, done, psel, penable, pwrite, vec_valid, vec_last});
    end
    checks++;
    if (paddr !== 6'd0 || pwdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus: paddr=%h pwdata=%h required 0", paddr, pwdata);
    end
    checks++;
    if (vec_data !== '0) begin
      errors++;
      $display("FAIL reset_vec_data: nonzero, required 0");
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || psel !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b psel=%b required 0 0", busy, psel);
    end
  endtask

  task automatic test_zero_cols();
    clear_stats();
    pulse_start(8'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b required 1 0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_pulse: done=%b required 0", done);
    end
    tick();
    checks++;
    if (psel_cyc != 0) begin
      errors++;
      $display("FAIL zero_no_apb: psel cycles=%0d required 0", psel_cyc);
    end
  endtask

  task automatic test_poll_not_ready();
    zero_target = 3;
    vec_ready   = 1'b1;
    clear_stats();
    pulse_start(8'd1);
    wait_done(5000, "poll");
    tick();
    checks++;
    if (poll_n != 4) begin
      errors++;
      $display("FAIL poll_count: got %0d required 4", poll_n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (poll_t[i+1] - poll_t[i] != int'(GAP) + 2) begin
        errors++;
        $display("FAIL poll_spacing%0d: got %0d required %0d", i, poll_t[i+1] - poll_t[i], GAP + 2);
      end
    end
    checks++;
    if (first_idx !== 32'd0) begin
      errors++;
      $display("FAIL poll_first_idx: got %0d required 0", first_idx);
    end
    checks++;
    if (vec_n != int'(VPC)) begin
      errors++;
      $display("FAIL poll_vec_count: got %0d required %0d", vec_n, VPC);
    end
    zero_target = 0;
  endtask

  task automatic test_one_column();
    vec_ready = 1'b1;
    clear_stats();
    pulse_start(8'd1);
    wait_done(5000, "onecol");
    tick();
    checks++;
    if (poll_n != 1) begin
      errors++; $display("FAIL onecol_polls: got %0d required 1", poll_n);
    end
    checks++;
    if (idx_n != 288 || pay_n != 288) begin
      errors++; $display("FAIL onecol_word_xfers: idx=%0d pay=%0d required 288 288", idx_n, pay_n);
    end
    checks++;
    if (rel_n != 8 || rel_bad != 0) begin
      errors++; $display("FAIL onecol_release: n=%0d bad=%0d required 8 0", rel_n, rel_bad);
    end
    checks++;
    if (xfer_n != 585 || dir_bad != 0) begin
      errors++; $display("FAIL onecol_total: xfers=%0d dir_bad=%0d required 585 0", xfer_n, dir_bad);
    end
    checks++;
    if (vec_n != 8 || done_n != 1) begin
      errors++; $display("FAIL onecol_vec_done: vecs=%0d done=%0d required 8 1", vec_n, done_n);
    end
    check_vectors(8, "onecol");
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] snap;
    int k = 0;
    int bad = 0;
    vec_ready = 1'b0;
    clear_stats();
    pulse_start(8'd1);
    while (!vec_valid && k < 2000) begin
      tick();
      k++;
    end
    checks++;
    if (vec_valid !== 1'b1) begin
      errors++; $display("FAIL bp_valid_timeout: vec_valid_o=%b required 1", vec_valid);
    end
    snap = vec_data;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (vec_data !== snap || psel !== 1'b0 || vec_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold: %0d unstable/active cycles of 50, required 0", bad);
    end
    vec_ready = 1'b1;
    tick();
    checks++;
    if (vec_valid !== 1'b0 || psel !== 1'b1 || penable !== 1'b0 || paddr !== 6'h30 || pwdata !== 32'd0) begin
      errors++;
      $display("FAIL bp_resume: valid=%b psel=%b pen=%b paddr=%h wdata=%0d required 0 1 0 30 0",
               vec_valid, psel, penable, paddr, pwdata);
    end
    wait_done(5000, "bp");
    tick();
    checks++;
    if (vec_n != 8) begin
      errors++; $display("FAIL bp_vec_count: got %0d required 8", vec_n);
    end
    check_vectors(8, "bp");
  endtask

  task automatic test_wait_states();
    int k = 0;
    int busy_bad = 0;
    wait_mode = 1'b1;
    vec_ready = 1'b1;
    clear_stats();
    pulse_start(8'd2);
    while (!done && k < 12000) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
      k++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL ws_timeout: done_o not seen within 12000 cycles");
    end
    checks++;
    if (busy_bad != 0) begin
      errors++; $display("FAIL ws_busy: busy low %0d cycles, required 0", busy_bad);
    end
    tick();
    checks++;
    if (vec_n != 16 || poll_n != 2 || done_n != 1) begin
      errors++;
      $display("FAIL ws_counts: vecs=%0d polls=%0d done=%0d required 16 2 1", vec_n, poll_n, done_n);
    end
    check_vectors(16, "ws");
    wait_mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    vec_ready = 1'b1;
    clear_stats();
    pulse_start(8'd1);
    while (!(vec_n == 3 && psel && paddr == 6'h34) && k < 3000) begin
      tick();
      k++;
    end
    checks++;
    if (!(vec_n == 3 && psel === 1'b1 && paddr === 6'h34)) begin
      errors++; $display("FAIL rstmid_reach: vecs=%0d psel=%b paddr=%h required 3 1 34", vec_n, psel, paddr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({psel, penable, pwrite, busy, done, vec_valid, vec_last} !== 7'b0 || vec_data !== '0 || paddr !== 6'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: ctrl=%b paddr=%h required 0000000 00",
               {psel, penable, pwrite, busy, done, vec_valid, vec_last}, paddr);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_stats();
    pulse_start(8'd1);
    wait_done(5000, "rstmid");
    tick();
    checks++;
    if (vec_n != 8 || done_n != 1) begin
      errors++; $display("FAIL rstmid_rerun: vecs=%0d done=%0d required 8 1", vec_n, done_n);
    end
    check_vectors(8, "rstmid");
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    col_cnt     = 8'd0;
    vec_ready   = 1'b0;
    clr         = 1'b1;
    wait_mode   = 1'b0;
    zero_target = 0;
    cyc         = 0;
    tick();
    clr = 1'b0;
    test_reset();
    test_zero_cols();
    test_poll_not_ready();
    test_one_column();
    test_backpressure();
    test_wait_states();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
